// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels and bit-period helper.
// Used by the transmitter and intended for the future receive-side block.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLatch,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses bit_done on the last cycle of every bit period.
// restart zeroes the phase so a frame's first bit period starts cleanly.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops one byte at a time from an upstream FIFO and
// sends it LSB-first as 8N1 or 8N2; tx and pop come straight from registers.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] data_in,
    output logic       pop,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic StopLast = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx_drain: CLK_HZ/BAUD must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_drain: STOP_BITS must be 1 or 2");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        tx_q, tx_d;
    logic        pop_q, pop_d;
    logic        restart;
    logic        bit_done;

    assign restart = (state_q == StLatch);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            pop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            pop_q      <= pop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StLatch;
            end
            StLatch: begin
                shift_d    = data_in;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
                state_d    = StStart;
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (stop_idx_q == StopLast) begin
                        state_d = StIdle;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered tx/pop line up
    // with the state they belong to.
    always_comb begin
        tx_d  = UART_IDLE_LEVEL;
        pop_d = 1'b0;
        unique case (state_d)
            StPop:   pop_d = 1'b1;
            StStart: tx_d  = UART_START_LEVEL;
            StData:  tx_d  = shift_d[0];
            default: ;
        endcase
    end

    assign tx   = tx_q;
    assign pop  = pop_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: dut 0 runs 8N1, dut 1 runs 8N2, both 16 clocks/bit,
// fed by a small FIFO model; decoded frames are checked against a scoreboard.
module tb_uart_tx_drain;

    logic            clk     = 1'b0;
    logic            reset   = 1'b1;
    logic [1:0]      empty_r = 2'b11;
    logic [1:0][7:0] din     = '0;
    logic [1:0]      pop_w;
    logic [1:0]      tx_w;
    logic [1:0]      busy_w;

    int n_cmp   = 0;
    int n_bad   = 0;
    int ncyc    = 0;
    int pop_cnt [2] = '{0, 0};
    int pop_t0  [$];

    logic [7:0] fifo0 [$];
    logic [7:0] fifo1 [$];
    logic [7:0] sb0   [$];
    logic [7:0] sb1   [$];

    typedef struct {
        int         g;
        logic [7:0] data;
        int         frame_len;
        int         stop_len;
    } vec_t;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx_drain #(
            .CLK_HZ   (16),
            .BAUD     (1),
            .STOP_BITS(g + 1)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .empty  (empty_r[g]),
            .data_in(din[g]),
            .pop    (pop_w[g]),
            .tx     (tx_w[g]),
            .busy   (busy_w[g])
        );
    end

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (pop_w[g] === 1'b1) pop_cnt[g] <= pop_cnt[g] + 1;
        end
        if (pop_w[0] === 1'b1) pop_t0.push_back(ncyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // One clock step; the FIFO model answers a pop by presenting the byte at once.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_w[0] === 1'b1 && fifo0.size() > 0) din[0] = fifo0.pop_front();
        if (pop_w[1] === 1'b1 && fifo1.size() > 0) din[1] = fifo1.pop_front();
        empty_r[0] = (fifo0.size() == 0);
        empty_r[1] = (fifo1.size() == 0);
    endtask

    task automatic push_byte(input int g, input logic [7:0] b);
        if (g == 0) begin
            fifo0.push_back(b);
            sb0.push_back(b);
        end else begin
            fifo1.push_back(b);
            sb1.push_back(b);
        end
        empty_r[g] = 1'b0;
    endtask

    // Waits for a start bit, records the whole frame cycle by cycle and checks
    // the decoded byte and exact line shape against the scoreboard entry.
    task automatic capture(input int g, input bit toggle, output int busy_fall,
                           output int waited, output int tail_high);
        int         n;
        int         shape_err;
        logic [7:0] want;
        logic [7:0] got;
        logic       lvl;
        logic       tog;
        logic       line [200];
        n         = (10 + g) * 16;
        waited    = 0;
        busy_fall = -1;
        tail_high = -1;
        while (tx_w[g] !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        if (tx_w[g] !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_timeout dut%0d: tx %b after 400 cycles, required 0", g, tx_w[g]);
            return;
        end
        if (g == 0 && sb0.size() > 0) want = sb0.pop_front();
        else if (g == 1 && sb1.size() > 0) want = sb1.pop_front();
        else want = 'x;
        tog = empty_r[g];
        for (int i = 0; i < n; i++) begin
            line[i] = tx_w[g];
            if (busy_fall < 0 && busy_w[g] === 1'b0) busy_fall = i;
            tick();
            if (toggle && (i + 1) >= 16 && (i + 1) < 144) begin
                tog        = ~tog;
                empty_r[g] = tog;
            end
        end
        for (int i = 0; busy_fall < 0 && i < 64; i++) begin
            if (busy_w[g] === 1'b0) busy_fall = n + i;
            else tick();
        end
        for (int k = 0; k < 8; k++) got[k] = line[16 * (k + 1) + 8];
        shape_err = 0;
        for (int i = 0; i < n; i++) begin
            if (i < 16) lvl = 1'b0;
            else if (i < 144) lvl = want[(i - 16) / 16];
            else lvl = 1'b1;
            if (line[i] !== lvl) shape_err++;
        end
        tail_high = 0;
        for (int i = n - 1; i >= 0 && line[i] === 1'b1; i--) tail_high++;
        check($sformatf("dut%0d_byte", g), 32'(got), 32'(want));
        check($sformatf("dut%0d_shape_err_cycles", g), shape_err, 0);
    endtask

    initial begin
        vec_t vecs [5];
        int   bf, w, th, bf2, w2, th2, p0, p1, gap, sz;
        int   bad_tx, bad_pop, bad_busy;

        vecs[0] = '{0, 8'hA5, 160, 16};
        vecs[1] = '{1, 8'h55, 176, 32};
        vecs[2] = '{0, 8'h3C, 160, 16};
        vecs[3] = '{1, 8'h80, 176, 32};
        vecs[4] = '{0, 8'h01, 160, 16};

        // Reset and idle
        reset = 1'b1;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset_tx%0d", g), 32'(tx_w[g]), 1);
            check($sformatf("reset_pop%0d", g), 32'(pop_w[g]), 0);
            check($sformatf("reset_busy%0d", g), 32'(busy_w[g]), 0);
        end
        reset    = 1'b0;
        bad_tx   = 0;
        bad_pop  = 0;
        bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_w !== 2'b11) bad_tx++;
            if (pop_w !== 2'b00) bad_pop++;
            if (busy_w !== 2'b00) bad_busy++;
        end
        check("idle_tx_not_high", bad_tx, 0);
        check("idle_pop_seen", bad_pop, 0);
        check("idle_busy_seen", bad_busy, 0);

        // Single frames, both stop-bit settings
        for (int v = 0; v < 5; v++) begin
            p0 = pop_cnt[vecs[v].g];
            push_byte(vecs[v].g, vecs[v].data);
            capture(vecs[v].g, 1'b0, bf, w, th);
            check($sformatf("vec%0d_frame_len", v), bf, vecs[v].frame_len);
            check($sformatf("vec%0d_stop_len", v), bf - 144, vecs[v].stop_len);
            check($sformatf("vec%0d_pops", v), pop_cnt[vecs[v].g] - p0, 1);
        end

        // Back-to-back frames with the FIFO left non-empty
        p0 = pop_cnt[0];
        push_byte(0, 8'h00);
        push_byte(0, 8'hFF);
        capture(0, 1'b0, bf, w, th);
        capture(0, 1'b0, bf2, w2, th2);
        check("b2b_frame1_len", bf, 160);
        check("b2b_frame2_len", bf2, 160);
        check("b2b_high_between", th + w2, 19);
        check("b2b_pops", pop_cnt[0] - p0, 2);
        sz  = pop_t0.size();
        gap = (sz >= 2) ? (pop_t0[sz - 1] - pop_t0[sz - 2]) : -1;
        check("b2b_pop_gap", gap, 163);

        // empty toggling during DATA must not disturb the frame
        p0 = pop_cnt[0];
        push_byte(0, 8'hC3);
        capture(0, 1'b1, bf, w, th);
        check("toggle_frame_len", bf, 160);
        repeat (5) tick();
        check("toggle_pops", pop_cnt[0] - p0, 1);

        // Reset during data bit 4 of 0x0F
        p0 = pop_cnt[0];
        fifo0.push_back(8'h0F);
        empty_r[0] = 1'b0;
        w = 0;
        while (tx_w[0] !== 1'b0 && w < 400) begin
            tick();
            w++;
        end
        check("rst_start_seen", 32'(tx_w[0]), 0);
        repeat (85) tick();
        check("rst_pre_bit4", 32'(tx_w[0]), 0);
        p1    = pop_cnt[0];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_tx_next_edge", 32'(tx_w[0]), 1);
        check("rst_busy_next_edge", 32'(busy_w[0]), 0);
        bad_tx   = 0;
        bad_busy = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_w[0] !== 1'b1) bad_tx++;
            if (busy_w[0] !== 1'b0) bad_busy++;
        end
        check("rst_after_tx_low", bad_tx, 0);
        check("rst_after_busy", bad_busy, 0);
        check("rst_extra_pops", pop_cnt[0] - p1, 0);
        check("rst_total_pops", pop_cnt[0] - p0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
